// File: rtl/uart_pulse_cmd_decoder.sv
`timescale 1ns/1ps
// Frame parser for the double-pulse generator: HEADER CMD D3 D2 D1 D0 CHK bytes
// update the four pulse timing registers or fire the startclock trigger.
module uart_pulse_cmd_decoder #(
    parameter logic [7:0]  HEADER           = 8'hAA,
    parameter int unsigned START_LOW_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] pulse2start1,
    output logic [31:0] pulse2end1,
    output logic [31:0] pulse2start2,
    output logic [31:0] pulse2end2,
    output logic        startclock,
    output logic        cmd_ok,
    output logic        cmd_err,
    output logic [1:0]  err_code
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LO_W = $clog2(START_LOW_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, GET_CMD, GET_DATA, GET_CHK, EXEC} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d, chk_q, chk_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        idx_q, idx_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [31:0]       s1_q, s1_d, e1_q, e1_d, s2_q, s2_d, e2_q, e2_d;
    logic              sc_q, sc_d;
    logic [LO_W-1:0]   lo_cnt_q, lo_cnt_d;
    logic              ok_q, ok_d, err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic [7:0]        xsum;
    logic              ordered;

    assign xsum    = cmd_q ^ data_q[31:24] ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0];
    assign ordered = (s1_q < e1_q) && (e1_q < s2_q) && (s2_q < e2_q);

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        chk_d    = chk_q;
        data_d   = data_q;
        idx_d    = idx_q;
        to_cnt_d = '0;
        s1_d     = s1_q;
        e1_d     = e1_q;
        s2_d     = s2_q;
        e2_d     = e2_q;
        sc_d     = sc_q;
        lo_cnt_d = lo_cnt_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;

        // Low-window countdown; a fire in EXEC below overrides it with a reload.
        if (!sc_q) begin
            lo_cnt_d = lo_cnt_q - LO_W'(1);
            if (lo_cnt_q == LO_W'(1)) sc_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == HEADER) state_d = GET_CMD;
            end
            GET_CMD: begin
                if (rx_valid) begin
                    cmd_d   = rx_data;
                    idx_d   = '0;
                    state_d = GET_DATA;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    data_d = {data_q[23:0], rx_data};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = GET_CHK;
                end
            end
            GET_CHK: begin
                if (rx_valid) begin
                    chk_d   = rx_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
                if (chk_q != xsum) begin
                    err_d  = 1'b1;
                    code_d = 2'd1;
                end else begin
                    case (cmd_q)
                        8'h01:   begin s1_d = data_q; ok_d = 1'b1; end
                        8'h02:   begin e1_d = data_q; ok_d = 1'b1; end
                        8'h03:   begin s2_d = data_q; ok_d = 1'b1; end
                        8'h04:   begin e2_d = data_q; ok_d = 1'b1; end
                        8'h20: begin
                            s1_d = '0;
                            e1_d = '0;
                            s2_d = '0;
                            e2_d = '0;
                            ok_d = 1'b1;
                        end
                        8'h10: begin
                            if (ordered) begin
                                ok_d     = 1'b1;
                                sc_d     = 1'b0;
                                lo_cnt_d = LO_W'(START_LOW_CYCLES);
                            end else begin
                                err_d  = 1'b1;
                                code_d = 2'd3;
                            end
                        end
                        default: begin
                            err_d  = 1'b1;
                            code_d = 2'd2;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte timeout, only while a frame is partially received.
        if (state_q inside {GET_CMD, GET_DATA, GET_CHK} && !rx_valid) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                err_d   = 1'b1;
                code_d  = 2'd0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            chk_q    <= '0;
            data_q   <= '0;
            idx_q    <= '0;
            to_cnt_q <= '0;
            s1_q     <= '0;
            e1_q     <= '0;
            s2_q     <= '0;
            e2_q     <= '0;
            sc_q     <= 1'b1;
            lo_cnt_q <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            chk_q    <= chk_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            to_cnt_q <= to_cnt_d;
            s1_q     <= s1_d;
            e1_q     <= e1_d;
            s2_q     <= s2_d;
            e2_q     <= e2_d;
            sc_q     <= sc_d;
            lo_cnt_q <= lo_cnt_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign pulse2start1 = s1_q;
    assign pulse2end1   = e1_q;
    assign pulse2start2 = s2_q;
    assign pulse2end2   = e2_q;
    assign startclock   = sc_q;
    assign cmd_ok       = ok_q;
    assign cmd_err      = err_q;
    assign err_code     = code_q;

endmodule

// File: tb/tb_uart_pulse_cmd_decoder.sv
`timescale 1ns/1ps
// Scoreboard bench: two decoders (short and long trigger window) share one byte stream;
// a reference model predicts every response and the per-cycle startclock level.
module tb_uart_pulse_cmd_decoder;

    localparam int         TO    = 100;
    localparam int         LOW_A = 4;
    localparam int         LOW_B = 12;
    localparam logic [7:0] HDR   = 8'hAA;

    logic clk = 1'b0, rst_n = 1'b1, rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [31:0] a_s1, a_e1, a_s2, a_e2, b_s1, b_e1, b_s2, b_e2;
    logic a_sc, a_ok, a_err, b_sc, b_ok, b_err;
    logic [1:0] a_code, b_code;

    uart_pulse_cmd_decoder #(.HEADER(HDR), .START_LOW_CYCLES(LOW_A), .TIMEOUT_CYCLES(TO)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .pulse2start1(a_s1), .pulse2end1(a_e1), .pulse2start2(a_s2), .pulse2end2(a_e2),
        .startclock(a_sc), .cmd_ok(a_ok), .cmd_err(a_err), .err_code(a_code));

    uart_pulse_cmd_decoder #(.HEADER(HDR), .START_LOW_CYCLES(LOW_B), .TIMEOUT_CYCLES(TO)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .pulse2start1(b_s1), .pulse2end1(b_e1), .pulse2start2(b_s2), .pulse2end2(b_e2),
        .startclock(b_sc), .cmd_ok(b_ok), .cmd_err(b_err), .err_code(b_code));

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        int                due;
        int                tol;
        bit                ok;
        logic [1:0]        code;
        logic [3:0][31:0]  r;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: r[0]=start1, r[1]=end1, r[2]=start2, r[3]=end2; low windows [ls, le).
    logic [3:0][31:0] m_r = '0;
    logic [1:0]       m_code = 2'd0;
    int ls_a = -100, le_a = -100, ls_b = -100, le_b = -100;
    int falls_a = 0, falls_b = 0;
    logic prev_a = 1'b1, prev_b = 1'b1;

    task automatic model_reset();
        m_r = '0;
        m_code = 2'd0;
        ls_a = -100; le_a = -100; ls_b = -100; le_b = -100;
        exp_q.delete();
    endtask

    task automatic push_exp(input int due, input int tol, input bit ok);
        exp_t e;
        e.due = due; e.tol = tol; e.ok = ok; e.code = m_code; e.r = m_r;
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] cmd, input logic [31:0] d);
        return cmd ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gap);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'h00;
        if (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] d, input logic [7:0] chk, input bit gap);
        int due;
        bit ok;
        send_byte(HDR, gap);
        send_byte(cmd, gap);
        for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], gap);
        due = cyc + 2;
        ok  = 1'b0;
        if (chk !== xsum(cmd, d)) m_code = 2'd1;
        else case (cmd)
            8'h01, 8'h02, 8'h03, 8'h04: begin m_r[int'(cmd) - 1] = d; ok = 1'b1; end
            8'h20: begin m_r = '0; ok = 1'b1; end
            8'h10: begin
                if (m_r[0] < m_r[1] && m_r[1] < m_r[2] && m_r[2] < m_r[3]) begin
                    ok = 1'b1;
                    if (due > le_a) ls_a = due;
                    le_a = due + LOW_A;
                    if (due > le_b) ls_b = due;
                    le_b = due + LOW_B;
                end else m_code = 2'd3;
            end
            default: m_code = 2'd2;
        endcase
        push_exp(due, 0, ok);
        send_byte(chk, gap);
        if (!gap) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [31:0] d);
        send_frame(cmd, d, xsum(cmd, d), 1'b1);
    endtask

    // Response and trigger monitor, sampled mid-cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        prev_a <= a_sc;
        prev_b <= b_sc;
        if (rst_n) begin
            if (prev_a && !a_sc) falls_a++;
            if (prev_b && !b_sc) falls_b++;
            check("startclock_a", a_sc, !(cyc >= ls_a && cyc < le_a));
            check("startclock_b", b_sc, !(cyc >= ls_b && cyc < le_b));
            if (a_ok || a_err) begin
                if (exp_q.size() == 0) check("unexp_rsp", {a_ok, a_err}, 2'b00);
                else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", (cyc >= e.due - e.tol) && (cyc <= e.due + e.tol), 1'b1);
                    check("cmd_ok", a_ok, e.ok);
                    check("cmd_err", a_err, !e.ok);
                    check("err_code", a_code, e.code);
                    check("start1", a_s1, e.r[0]);
                    check("end1", a_e1, e.r[1]);
                    check("start2", a_s2, e.r[2]);
                    check("end2", a_e2, e.r[3]);
                    check("b_ok_err", {b_ok, b_err}, {e.ok, !e.ok});
                    check("b_code", b_code, e.code);
                    check("b_regs", {b_s1 ^ b_e1 ^ b_s2 ^ b_e2}, e.r[0] ^ e.r[1] ^ e.r[2] ^ e.r[3]);
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due + exp_q[0].tol) begin
                e = exp_q.pop_front();
                check("rsp_missing", cyc, e.due);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_regs"}, a_s1 | a_e1 | a_s2 | a_e2, 32'd0);
        check({tag, "_sc"}, {a_sc, b_sc}, 2'b11);
        check({tag, "_okerr"}, {a_ok, a_err}, 2'b00);
        check({tag, "_code"}, a_code, 2'd0);
    endtask

    initial begin : wdog
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin : stim
        int c, fa0, fb0;
        #5 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Stray bytes in IDLE are ignored.
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);

        frame(8'h01, 32'd1000);
        frame(8'h02, 32'd2000);
        frame(8'h03, 32'd3000);
        frame(8'h04, 32'd4000);
        frame(8'h10, 32'd0);
        repeat (8) @(posedge clk);
        #1;

        // Unordered timing rejects the fire.
        frame(8'h02, 32'd500);
        frame(8'h10, 32'd0);

        send_frame(8'h02, 32'h0000_0005, 8'h00, 1'b1);
        send_frame(8'h7F, 32'd0, 8'h7F, 1'b1);

        // Header in data position is plain data.
        frame(8'h03, {HDR, 24'h000BB8});
        frame(8'h03, 32'd3000);

        // Timeout after HEADER + CMD, then a normal frame.
        send_byte(HDR, 1'b1);
        c = cyc;
        send_byte(8'h02, 1'b1);
        m_code = 2'd0;
        push_exp(c + TO + 1, 1, 1'b0);
        repeat (TO + 5) @(posedge clk);
        #1;
        frame(8'h02, 32'd2000);

        // Back-to-back fires: dut_b is still low at the second one.
        fa0 = falls_a;
        fb0 = falls_b;
        send_frame(8'h10, 32'd0, 8'h10, 1'b0);
        send_frame(8'h10, 32'd0, 8'h10, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("falls_a", falls_a - fa0, 2);
        check("falls_b", falls_b - fb0, 1);

        // Reset after D1, then fire and reset while low.
        send_byte(HDR, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe");
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        frame(8'h03, 32'd77);
        frame(8'h10, 32'd0);
        frame(8'h01, 32'd1);
        frame(8'h02, 32'd2);
        frame(8'h04, 32'd78);
        send_frame(8'h10, 32'd0, 8'h10, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midfire");
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        frame(8'h01, 32'hFFFF_FFFE);
        frame(8'h20, 32'h1234_5678);
        repeat (10) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
